// File: rtl/binario_para_bcd_sequencial_if.sv
// Handshake and data bundle for the sequential binary-to-BCD converter.
//   inicio     start request (master -> slave)
//   binario    value to convert (master -> slave)
//   com_sinal  treat binario as two's complement (master -> slave)
//   ocupado    conversion in progress (slave -> master)
//   pronto     one-cycle result-valid pulse (slave -> master)
//   bcd        packed BCD digits, [3:0] = units (slave -> master)
//   sinal      result is negative (slave -> master)
//   estouro    magnitude did not fit in DIGITOS digits (slave -> master)
interface binario_para_bcd_sequencial_if #(
  parameter int LARGURA = 8,
  parameter int DIGITOS = 3
);
  logic                   inicio;
  logic [LARGURA-1:0]     binario;
  logic                   com_sinal;
  logic                   ocupado;
  logic                   pronto;
  logic [4*DIGITOS-1:0]   bcd;
  logic                   sinal;
  logic                   estouro;

  modport master (
    output inicio, binario, com_sinal,
    input  ocupado, pronto, bcd, sinal, estouro
  );

  modport slave (
    input  inicio, binario, com_sinal,
    output ocupado, pronto, bcd, sinal, estouro
  );
endinterface

// File: rtl/binario_para_bcd_sequencial.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of binario_para_bcd_sequencial_if (start/done handshake,
//          binary input, BCD/sign/overflow results)
// Results are registered and only change on the edge that raises pronto, so the
// display side never sees intermediate digit values.
module binario_para_bcd_sequencial #(
  parameter int LARGURA = 8,
  parameter int DIGITOS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  binario_para_bcd_sequencial_if.slave  bus
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam int BW = 4 * DIGITOS;

  typedef enum logic {OCIOSO = 1'b0, CONVERTE = 1'b1} estado_t;

  estado_t            state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [LARGURA-1:0] shift_reg, shift_next;
  logic [BW-1:0]      dig_reg, dig_next;
  logic               acc_reg, acc_next;
  logic               sinal_int_reg, sinal_int_next;
  logic [BW-1:0]      bcd_reg, bcd_next;
  logic               sinal_reg, sinal_next;
  logic               estouro_reg, estouro_next;
  logic               pronto_reg, pronto_next;

  logic [BW-1:0]      ajustado;
  logic [BW-1:0]      deslocado;
  logic [LARGURA-1:0] magnitude;
  logic               negativo;

  // Add-3 correction applied independently to every digit (no inter-digit carry).
  genvar gi;
  generate
    for (gi = 0; gi < DIGITOS; gi++) begin : g_ajuste
      assign ajustado[4*gi+3:4*gi] = (dig_reg[4*gi+3:4*gi] >= 4'd5)
                                     ? dig_reg[4*gi+3:4*gi] + 4'd3
                                     : dig_reg[4*gi+3:4*gi];
    end
  endgenerate

  // The bit shifted out of the top digit is worth 10^DIGITOS; dropping it keeps
  // the digits equal to the value mod 10^DIGITOS, and it feeds the overflow flag.
  assign deslocado = {ajustado[BW-2:0], shift_reg[LARGURA-1]};

  // Plain LARGURA-bit negation: the most negative input maps to 2^(LARGURA-1),
  // which is the correct magnitude when read as unsigned.
  assign negativo  = bus.com_sinal & bus.binario[LARGURA-1];
  assign magnitude = negativo ? (~bus.binario + {{(LARGURA-1){1'b0}}, 1'b1})
                              : bus.binario;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    dig_next       = dig_reg;
    acc_next       = acc_reg;
    sinal_int_next = sinal_int_reg;
    bcd_next       = bcd_reg;
    sinal_next     = sinal_reg;
    estouro_next   = estouro_reg;
    pronto_next    = 1'b0;

    case (state_reg)
      OCIOSO: begin
        if (bus.inicio) begin
          state_next     = CONVERTE;
          shift_next     = magnitude;
          dig_next       = '0;
          acc_next       = 1'b0;
          sinal_int_next = negativo;
          cnt_next       = CW'(LARGURA);
        end
      end
      CONVERTE: begin
        dig_next   = deslocado;
        shift_next = {shift_reg[LARGURA-2:0], 1'b0};
        acc_next   = acc_reg | ajustado[BW-1];
        cnt_next   = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next   = OCIOSO;
          bcd_next     = deslocado;
          sinal_next   = sinal_int_reg;
          estouro_next = acc_reg | ajustado[BW-1];
          pronto_next  = 1'b1;
        end
      end
      default: state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= OCIOSO;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      dig_reg       <= '0;
      acc_reg       <= 1'b0;
      sinal_int_reg <= 1'b0;
      bcd_reg       <= '0;
      sinal_reg     <= 1'b0;
      estouro_reg   <= 1'b0;
      pronto_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      dig_reg       <= dig_next;
      acc_reg       <= acc_next;
      sinal_int_reg <= sinal_int_next;
      bcd_reg       <= bcd_next;
      sinal_reg     <= sinal_next;
      estouro_reg   <= estouro_next;
      pronto_reg    <= pronto_next;
    end
  end

  assign bus.ocupado = (state_reg == CONVERTE);
  assign bus.pronto  = pronto_reg;
  assign bus.bcd     = bcd_reg;
  assign bus.sinal   = sinal_reg;
  assign bus.estouro = estouro_reg;

endmodule

// File: tb/tb_binario_para_bcd_sequencial.sv
// Directed testbench for binario_para_bcd_sequencial: three instances cover the
// default 8-bit/3-digit configuration, a 2-digit overflow configuration and a
// 16-bit/5-digit back-to-back configuration.
module tb_binario_para_bcd_sequencial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  binario_para_bcd_sequencial_if #(.LARGURA(8),  .DIGITOS(3)) bus_a ();
  binario_para_bcd_sequencial_if #(.LARGURA(8),  .DIGITOS(2)) bus_b ();
  binario_para_bcd_sequencial_if #(.LARGURA(16), .DIGITOS(5)) bus_c ();

  binario_para_bcd_sequencial #(.LARGURA(8),  .DIGITOS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  binario_para_bcd_sequencial #(.LARGURA(8),  .DIGITOS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  binario_para_bcd_sequencial #(.LARGURA(16), .DIGITOS(5)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One conversion on the default instance with full handshake checks.
  task automatic run_a(input string tag, input logic [7:0] b, input logic s,
                       input logic [11:0] eb, input logic es, input logic ee);
    int lat;
    int busy;
    @(negedge clk);
    bus_a.inicio = 1'b1; bus_a.binario = b; bus_a.com_sinal = s;
    @(posedge clk); #1;
    bus_a.inicio = 1'b0;
    lat = 0; busy = 0;
    while (bus_a.pronto !== 1'b1 && lat < 40) begin
      if (bus_a.ocupado === 1'b1) busy++;
      @(posedge clk); #1;
      lat++;
    end
    $display("a %s: binario=0x%02h com_sinal=%0b -> bcd=0x%03h sinal=%0b estouro=%0b latency=%0d",
             tag, b, s, bus_a.bcd, bus_a.sinal, bus_a.estouro, lat);
    chk({tag, "_latency"}, lat, 32'd8);
    chk({tag, "_busy_cycles"}, busy, 32'd8);
    chk({tag, "_ocupado_at_pronto"}, {31'd0, bus_a.ocupado}, 32'd0);
    chk({tag, "_bcd"}, {20'd0, bus_a.bcd}, {20'd0, eb});
    chk({tag, "_sinal"}, {31'd0, bus_a.sinal}, {31'd0, es});
    chk({tag, "_estouro"}, {31'd0, bus_a.estouro}, {31'd0, ee});
    @(posedge clk); #1;
    chk({tag, "_pronto_one_cycle"}, {31'd0, bus_a.pronto}, 32'd0);
  endtask

  // One conversion on the 2-digit instance.
  task automatic run_b(input string tag, input logic [7:0] b,
                       input logic [7:0] eb, input logic ee);
    int lat;
    @(negedge clk);
    bus_b.inicio = 1'b1; bus_b.binario = b; bus_b.com_sinal = 1'b0;
    @(posedge clk); #1;
    bus_b.inicio = 1'b0;
    lat = 0;
    while (bus_b.pronto !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("b %s: binario=%0d -> bcd=0x%02h estouro=%0b latency=%0d",
             tag, b, bus_b.bcd, bus_b.estouro, lat);
    chk({tag, "_latency"}, lat, 32'd8);
    chk({tag, "_bcd"}, {24'd0, bus_b.bcd}, {24'd0, eb});
    chk({tag, "_estouro"}, {31'd0, bus_b.estouro}, {31'd0, ee});
  endtask

  initial begin
    int lat;
    int cnt_p;
    int cnt_o;

    bus_a.inicio = 1'b0; bus_a.binario = '0; bus_a.com_sinal = 1'b0;
    bus_b.inicio = 1'b0; bus_b.binario = '0; bus_b.com_sinal = 1'b0;
    bus_c.inicio = 1'b0; bus_c.binario = '0; bus_c.com_sinal = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ocupado", {31'd0, bus_a.ocupado}, 32'd0);
    chk("reset_pronto",  {31'd0, bus_a.pronto},  32'd0);
    chk("reset_bcd",     {20'd0, bus_a.bcd},     32'd0);
    chk("reset_sinal",   {31'd0, bus_a.sinal},   32'd0);
    chk("reset_estouro", {31'd0, bus_a.estouro}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default configuration, unsigned and signed cases.
    run_a("u255",  8'd255, 1'b0, 12'h255, 1'b0, 1'b0);
    run_a("s80",   8'h80,  1'b1, 12'h128, 1'b1, 1'b0);
    run_a("sFF",   8'hFF,  1'b1, 12'h001, 1'b1, 1'b0);
    run_a("s00",   8'h00,  1'b1, 12'h000, 1'b0, 1'b0);
    run_a("u80",   8'h80,  1'b0, 12'h128, 1'b0, 1'b0);
    run_a("s7F",   8'h7F,  1'b1, 12'h127, 1'b0, 1'b0);

    // inicio pulsed mid-conversion must be ignored.
    @(negedge clk);
    bus_a.inicio = 1'b1; bus_a.binario = 8'd200; bus_a.com_sinal = 1'b0;
    @(posedge clk); #1;
    bus_a.inicio = 1'b0;
    lat = 0;
    while (bus_a.pronto !== 1'b1 && lat < 40) begin
      if (lat == 3) begin
        bus_a.inicio = 1'b1; bus_a.binario = 8'd7;
      end else begin
        bus_a.inicio = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus_a.inicio = 1'b0;
    $display("a ignore: binario=200 with extra inicio -> bcd=0x%03h latency=%0d", bus_a.bcd, lat);
    chk("ignore_latency", lat, 32'd8);
    chk("ignore_bcd", {20'd0, bus_a.bcd}, 32'h200);
    cnt_p = 0; cnt_o = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus_a.pronto === 1'b1) cnt_p++;
      if (bus_a.ocupado === 1'b1) cnt_o++;
    end
    chk("ignore_extra_pronto", cnt_p, 32'd0);
    chk("ignore_extra_ocupado", cnt_o, 32'd0);

    // Reset in the middle of a conversion after a prior result.
    run_a("u42", 8'd42, 1'b0, 12'h042, 1'b0, 1'b0);
    @(negedge clk);
    bus_a.inicio = 1'b1; bus_a.binario = 8'd99; bus_a.com_sinal = 1'b0;
    @(posedge clk); #1;
    bus_a.inicio = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("a reset: mid-conversion reset -> bcd=0x%03h ocupado=%0b", bus_a.bcd, bus_a.ocupado);
    chk("midrst_bcd",     {20'd0, bus_a.bcd},     32'd0);
    chk("midrst_ocupado", {31'd0, bus_a.ocupado}, 32'd0);
    chk("midrst_pronto",  {31'd0, bus_a.pronto},  32'd0);
    cnt_p = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus_a.pronto === 1'b1) cnt_p++;
    end
    chk("midrst_no_pronto", cnt_p, 32'd0);
    run_a("u13", 8'd13, 1'b0, 12'h013, 1'b0, 1'b0);

    // Two-digit instance: overflow behaviour.
    run_b("b99",  8'd99,  8'h99, 1'b0);
    run_b("b255", 8'd255, 8'h55, 1'b1);
    run_b("b100", 8'd100, 8'h00, 1'b1);

    // 16-bit/5-digit instance: back-to-back 65535 then 0.
    @(negedge clk);
    bus_c.inicio = 1'b1; bus_c.binario = 16'hFFFF; bus_c.com_sinal = 1'b0;
    @(posedge clk); #1;
    bus_c.inicio = 1'b0;
    lat = 0;
    while (bus_c.pronto !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("c first: binario=65535 -> bcd=0x%05h latency=%0d", bus_c.bcd, lat);
    chk("c1_latency", lat, 32'd16);
    chk("c1_bcd", {12'd0, bus_c.bcd}, 32'h65535);
    chk("c1_ocupado_at_pronto", {31'd0, bus_c.ocupado}, 32'd0);
    bus_c.inicio = 1'b1; bus_c.binario = 16'd0;
    @(posedge clk); #1;
    bus_c.inicio = 1'b0;
    chk("c2_accepted_on_pronto", {31'd0, bus_c.ocupado}, 32'd1);
    cnt_o = 0;
    lat = 0;
    while (bus_c.pronto !== 1'b1 && lat < 60) begin
      if (bus_c.ocupado !== 1'b1) cnt_o++;
      @(posedge clk); #1;
      lat++;
    end
    $display("c second: binario=0 -> bcd=0x%05h latency=%0d", bus_c.bcd, lat);
    chk("c2_latency", lat, 32'd16);
    chk("c2_no_idle_gap", cnt_o, 32'd0);
    chk("c2_bcd", {12'd0, bus_c.bcd}, 32'h00000);
    chk("c2_sinal", {31'd0, bus_c.sinal}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/binario_para_bcd_sequencial.md
# binario_para_bcd_sequencial

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It is the successor to the fixed 8-bit, two-digit combinational converter. The input width and BCD digit count are generic, an optional two's-complement mode is added, and the block flags overflow when the digit count is too small. It sits between arithmetic/counter logic and the 7-segment display drivers, with a start/done handshake.

## Interface
- LARGURA, 8: width of binary input, ≥ 2
- DIGITOS, 3: number of BCD output digits, ≥ 1; no relation to LARGURA is enforced, and overflow is flagged instead
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- inicio  in  1  start request; accepted only when ocupado=0
- binario  in  LARGURA  value to convert; sampled on the accepting edge
- com_sinal  in  1  1 = interpret binario as two's complement; sampled with binario
- ocupado  out  1  conversion in progress
- pronto  out  1  one-cycle pulse: results valid and updated
- bcd  out  4*DIGITOS  packed digits; [3:0] = units, [7:4] = tens, …
- sinal  out  1  1 = result is negative (only possible when com_sinal=1)
- estouro  out  1  1 = magnitude ≥ 10^DIGITOS; bcd holds magnitude mod 10^DIGITOS

## Operation
- FSM states: OCIOSO, CONVERTE. Bit counter cnt is ceil(log2(LARGURA+1)) bits wide.
- OCIOSO, inicio=1 → CONVERTE. Same edge:
  - Load the magnitude into the shift register: |binario| if com_sinal=1 and binario[LARGURA-1]=1, else binario.
  - Clear the internal digit register and the overflow accumulator.
  - Latch the sign; cnt=LARGURA.
- Magnitude is computed as LARGURA-bit unsigned two's-complement negation. The most negative value -2^(LARGURA-1) yields 2^(LARGURA-1), which is correct.
- Each CONVERTE cycle:
  - Every digit ≥5 gets +3, 4-bit, with no carry between digits.
  - The digit register shifts left 1, and the shift-register MSB enters the units LSB.
  - The bit leaving the top digit is ORed into the overflow accumulator.
  - cnt decrements.
- cnt reaches 0 after the LARGURA-th shift → OCIOSO. On that edge:
  - bcd, sinal and estouro load from internal state.
  - pronto=1 for exactly one cycle.
- bcd, sinal and estouro hold their last completed result throughout the next conversion. They never show intermediate values.
- inicio while ocupado=1 is ignored. It is not queued and does not disturb the conversion.
- sinal=0 whenever the magnitude is 0.

## Timing
- Reset values (rst_n=0 at an edge): state OCIOSO, ocupado=0, pronto=0, bcd=0, sinal=0, estouro=0, cnt=0.
- Reset has priority over inicio and over an in-flight conversion. A conversion that is aborted by reset produces no pronto.
- Accepting edge E0 → ocupado=1 from E0 to E0+LARGURA.
- At E0+LARGURA: ocupado=0, pronto=1, and outputs are updated. Latency is LARGURA cycles.
- Back-to-back: inicio=1 during the pronto cycle is accepted (ocupado=0), which gives a throughput of one result per LARGURA cycles.
- pronto and ocupado are never high simultaneously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Defaults, binario=255, com_sinal=0, inicio for 1 cycle:
  - pronto exactly 8 cycles after the accepting edge.
  - bcd=0x255, sinal=0, estouro=0.
  - ocupado high 8 cycles.
- Defaults, com_sinal=1:
  - binario=0x80 → bcd=0x128, sinal=1.
  - binario=0xFF → bcd=0x001, sinal=1.
  - binario=0x00 → bcd=0x000, sinal=0.
- DIGITOS=2, LARGURA=8:
  - binario=99 → bcd=0x99, estouro=0.
  - binario=255 → bcd=0x55, estouro=1.
  - binario=100 → bcd=0x00, estouro=1.
- Pulse inicio with binario=7 three cycles into a conversion of 200 → result bcd=0x200, only one pronto, no second conversion.
- rst_n=0 for 1 cycle mid-conversion after a prior result of 0x042:
  - Outputs go to 0 and no pronto is produced.
  - A new inicio with binario=13 → bcd=0x013 after 8 cycles.
- LARGURA=16, DIGITOS=5, back-to-back inicio on each pronto cycle with 65535 then 0:
  - bcd=0x65535 then 0x00000.
  - pronto 16 cycles apart.
  - ocupado has no idle gap.
